// File: rtl/vend_seq_ctrl_if.sv
// Vending controller bus: groups the coin/cancel pulses, the dispenser and
// hopper handshakes, and the status outputs of vend_seq_ctrl.
//   master : the vending datapath environment (drives pi_*, observes po_*)
//   slave  : the sequencing controller (observes pi_*, drives po_*)
// Signals:
//   pi_money_one / pi_money_half : one-cycle coin pulses (+2 / +1 half-units)
//   pi_cancel                    : one-cycle refund request
//   pi_disp_ack / pi_chg_ack     : dispenser / hopper acknowledges
//   po_disp_req / po_chg_req     : dispense / eject-one-half-coin requests
//   po_credit                    : current credit in half-units
//   po_busy                      : coin mechanism must reject coins
//   po_fault                     : one-cycle pulse on dispenser timeout
interface vend_seq_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             pi_money_one;
    logic             pi_money_half;
    logic             pi_cancel;
    logic             pi_disp_ack;
    logic             pi_chg_ack;
    logic             po_disp_req;
    logic             po_chg_req;
    logic [CNT_W-1:0] po_credit;
    logic             po_busy;
    logic             po_fault;

    modport master (
        output pi_money_one, pi_money_half, pi_cancel, pi_disp_ack, pi_chg_ack,
        input  po_disp_req, po_chg_req, po_credit, po_busy, po_fault
    );

    modport slave (
        input  pi_money_one, pi_money_half, pi_cancel, pi_disp_ack, pi_chg_ack,
        output po_disp_req, po_chg_req, po_credit, po_busy, po_fault
    );
endinterface

// File: rtl/vend_seq_ctrl.sv
// Beverage vending sequencing controller.
// Accumulates coin credit in half-units, requests a dispense once the price
// is reached, then pays back any remainder one half-coin at a time through
// the hopper handshake. Cancel refunds the whole credit; a dispenser that
// never acknowledges raises a fault pulse and the credit is refunded.
// Ports:
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : vend_seq_ctrl_if slave modport (see interface header)
// All bus outputs are registered.
module vend_seq_ctrl #(
    parameter int PRICE        = 3,
    parameter int CNT_W        = 3,
    parameter int DISP_TIMEOUT = 1000,
    parameter int TO_W         = 10
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    vend_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PRICE_C = CNT_W'(PRICE);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(DISP_TIMEOUT - 1);

    state_t           state_reg,    state_next;
    logic [CNT_W-1:0] credit_reg,   credit_next;
    logic [TO_W-1:0]  to_cnt_reg,   to_cnt_next;
    logic             disp_req_reg, disp_req_next;
    logic             chg_req_reg,  chg_req_next;
    logic             busy_reg,     busy_next;
    logic             fault_reg,    fault_next;

    logic [CNT_W-1:0] add_w;
    logic [CNT_W-1:0] sum_w;
    logic [CNT_W-1:0] remain_w;

    // One-coin weighs two half-units; both pulses together give 3.
    assign add_w    = CNT_W'({bus.pi_money_one, bus.pi_money_half});
    // PRICE+2 fits in CNT_W bits, so the sum never wraps in ACCUM.
    assign sum_w    = credit_reg + add_w;
    assign remain_w = credit_reg - PRICE_C;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= ST_ACCUM;
            credit_reg   <= '0;
            to_cnt_reg   <= '0;
            disp_req_reg <= 1'b0;
            chg_req_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            credit_reg   <= credit_next;
            to_cnt_reg   <= to_cnt_next;
            disp_req_reg <= disp_req_next;
            chg_req_reg  <= chg_req_next;
            busy_reg     <= busy_next;
            fault_reg    <= fault_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        credit_next   = credit_reg;
        to_cnt_next   = to_cnt_reg;
        disp_req_next = disp_req_reg;
        chg_req_next  = chg_req_reg;
        fault_next    = 1'b0;

        unique case (state_reg)
            ST_ACCUM: begin
                credit_next   = sum_w;
                disp_req_next = 1'b0;
                chg_req_next  = 1'b0;
                // A price-reaching coin wins over a same-cycle cancel.
                if (sum_w >= PRICE_C) begin
                    state_next    = ST_VEND;
                    disp_req_next = 1'b1;
                    to_cnt_next   = '0;
                end else if (bus.pi_cancel && (sum_w != '0)) begin
                    state_next   = ST_CHANGE;
                    chg_req_next = 1'b1;
                end
            end

            ST_VEND: begin
                // Ack is checked first so a same-cycle timeout never faults.
                if (bus.pi_disp_ack) begin
                    disp_req_next = 1'b0;
                    credit_next   = remain_w;
                    if (remain_w != '0) begin
                        state_next   = ST_CHANGE;
                        chg_req_next = 1'b1;
                    end else begin
                        state_next = ST_ACCUM;
                    end
                end else if (to_cnt_reg == TO_LAST) begin
                    // Credit left untouched: the customer gets it all back.
                    disp_req_next = 1'b0;
                    fault_next    = 1'b1;
                    state_next    = ST_CHANGE;
                    chg_req_next  = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            ST_CHANGE: begin
                if (chg_req_reg && bus.pi_chg_ack) begin
                    // Drop the request for one cycle after every coin.
                    credit_next  = credit_reg - 1'b1;
                    chg_req_next = 1'b0;
                    if (credit_reg == CNT_W'(1)) begin
                        state_next = ST_ACCUM;
                    end
                end else if (credit_reg != '0) begin
                    chg_req_next = 1'b1;
                end else begin
                    chg_req_next = 1'b0;
                    state_next   = ST_ACCUM;
                end
            end

            default: begin
                state_next    = ST_ACCUM;
                disp_req_next = 1'b0;
                chg_req_next  = 1'b0;
            end
        endcase

        busy_next = (state_next != ST_ACCUM);
    end

    assign bus.po_disp_req = disp_req_reg;
    assign bus.po_chg_req  = chg_req_reg;
    assign bus.po_credit   = credit_reg;
    assign bus.po_busy     = busy_reg;
    assign bus.po_fault    = fault_reg;

endmodule

// File: tb/tb_vend_seq_ctrl.sv
module tb_vend_seq_ctrl;

    localparam int PRICE        = 3;
    localparam int CNT_W        = 3;
    localparam int DISP_TIMEOUT = 8;
    localparam int TO_W         = 4;

    // Reference model phases (customer-level view of the machine).
    localparam int IDLE   = 0;
    localparam int SERVE  = 1;
    localparam int REFUND = 2;

    typedef struct {
        bit disp;
        bit chg;
        int credit;
        bit busy;
        bit fault;
    } exp_t;

    logic sys_clk;
    logic sys_rst_n;

    vend_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    vend_seq_ctrl #(
        .PRICE       (PRICE),
        .CNT_W       (CNT_W),
        .DISP_TIMEOUT(DISP_TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cyc = 0;

    // Reference model state
    int m_phase;
    int m_credit;
    int m_age;      // cycles since the dispense request went up
    bit m_disp;
    bit m_chg;
    bit m_fault;

    function automatic void model_reset();
        m_phase  = IDLE;
        m_credit = 0;
        m_age    = 0;
        m_disp   = 0;
        m_chg    = 0;
        m_fault  = 0;
    endfunction

    function automatic void model_step(bit one, bit half, bit cancel, bit dack, bit cack);
        m_fault = 0;
        if (m_phase == IDLE) begin
            m_credit = m_credit + 2 * one + half;
            if (m_credit >= PRICE) begin
                m_phase = SERVE;
                m_disp  = 1;
                m_age   = 0;
            end else if (cancel && m_credit > 0) begin
                m_phase = REFUND;
                m_chg   = 1;
            end
        end else if (m_phase == SERVE) begin
            m_age++;
            if (dack) begin
                m_disp   = 0;
                m_credit = m_credit - PRICE;
                if (m_credit > 0) begin
                    m_phase = REFUND;
                    m_chg   = 1;
                end else begin
                    m_phase = IDLE;
                end
            end else if (m_age == DISP_TIMEOUT) begin
                m_disp  = 0;
                m_fault = 1;
                m_phase = REFUND;
                m_chg   = 1;
            end
        end else begin
            if (m_chg && cack) begin
                m_credit--;
                m_chg = 0;
                if (m_credit == 0) m_phase = IDLE;
            end else begin
                m_chg = 1;
            end
        end
    endfunction

    task automatic cycle(bit one, bit half, bit cancel, bit dack, bit cack);
        exp_t e;
        @(negedge sys_clk);
        bus.pi_money_one  = one;
        bus.pi_money_half = half;
        bus.pi_cancel     = cancel;
        bus.pi_disp_ack   = dack;
        bus.pi_chg_ack    = cack;
        model_step(one, half, cancel, dack, cack);
        e.disp   = m_disp;
        e.chg    = m_chg;
        e.credit = m_credit;
        e.busy   = (m_phase != IDLE);
        e.fault  = m_fault;
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(string name);
        n_cmp++;
        if (bus.po_disp_req !== 1'b0 || bus.po_chg_req !== 1'b0 || bus.po_credit !== '0 ||
            bus.po_busy !== 1'b0 || bus.po_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got disp=%b chg=%b credit=%0d busy=%b fault=%b, want all 0",
                     name, bus.po_disp_req, bus.po_chg_req, bus.po_credit,
                     bus.po_busy, bus.po_fault);
        end else begin
            $display("check %s: all outputs 0", name);
        end
    endtask

    // Monitor: compares every registered output snapshot against the queue.
    always @(posedge sys_clk) begin
        exp_t e;
        #1;
        if (sys_rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cyc++;
            n_cmp++;
            if (bus.po_disp_req !== e.disp || bus.po_chg_req !== e.chg ||
                int'(bus.po_credit) != e.credit || bus.po_busy !== e.busy ||
                bus.po_fault !== e.fault) begin
                n_bad++;
                $display("FAIL cyc%0d outputs: got disp=%b chg=%b credit=%0d busy=%b fault=%b, want disp=%b chg=%b credit=%0d busy=%b fault=%b",
                         n_cyc, bus.po_disp_req, bus.po_chg_req, bus.po_credit, bus.po_busy,
                         bus.po_fault, e.disp, e.chg, e.credit, e.busy, e.fault);
            end else begin
                $display("cyc%0d ok: disp=%b chg=%b credit=%0d busy=%b fault=%b",
                         n_cyc, e.disp, e.chg, e.credit, e.busy, e.fault);
            end
        end
    end

    initial begin
        int dack_pct;
        bit one;
        bit half;
        bit cancel;
        bit dack;
        bit cack;

        sys_rst_n         = 1'b0;
        bus.pi_money_one  = 1'b0;
        bus.pi_money_half = 1'b0;
        bus.pi_cancel     = 1'b0;
        bus.pi_disp_ack   = 1'b0;
        bus.pi_chg_ack    = 1'b0;
        model_reset();
        #2;
        check_zero("reset_state");
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Three half coins, then ack: no change owed.
        cycle(0, 1, 0, 0, 0); cycle(0, 1, 0, 0, 0); cycle(0, 1, 0, 0, 0);
        idle(2); cycle(0, 0, 0, 1, 0); idle(2);
        // Two one coins: one half-coin of change after the ack.
        cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0); idle(1);
        cycle(0, 0, 0, 1, 0); idle(1); cycle(0, 0, 0, 0, 1); idle(2);
        // Half coin then cancel; cancel with nothing inserted.
        cycle(0, 1, 0, 0, 0); cycle(0, 0, 1, 0, 0); idle(1);
        cycle(0, 0, 0, 0, 1); idle(1); cycle(0, 0, 1, 0, 0); idle(1);
        // Dispenser timeout with credit 3, then hopper acks held high.
        cycle(0, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0); idle(DISP_TIMEOUT + 2);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1);
        idle(1);
        // Both coins at once; coins/cancel ignored while vending.
        cycle(1, 1, 0, 0, 0); cycle(1, 0, 1, 0, 0); cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0); idle(1);
        // Cancel alongside a price-reaching coin vends instead.
        cycle(0, 1, 0, 0, 0); cycle(1, 0, 1, 0, 0); idle(1);
        cycle(0, 0, 0, 1, 0); idle(1);
        // Ack exactly on the timeout cycle: ack wins.
        cycle(1, 1, 0, 0, 0); idle(DISP_TIMEOUT - 1); cycle(0, 0, 0, 1, 0); idle(1);

        // Randomized traffic.
        dack_pct = 20;
        for (int i = 0; i < 500; i++) begin
            if (m_phase == SERVE && m_age == 0)
                dack_pct = ($urandom_range(0, 2) == 0) ? 0 : 25;
            one    = ($urandom_range(0, 5) == 0);
            half   = ($urandom_range(0, 5) == 0);
            cancel = ($urandom_range(0, 9) == 0);
            dack   = ($urandom_range(0, 99) < dack_pct);
            cack   = ($urandom_range(0, 1) == 1);
            cycle(one, half, cancel, dack, cack);
        end
        idle(DISP_TIMEOUT + 2);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a refund with credit 2.
        cycle(0, 1, 0, 0, 0); cycle(0, 1, 0, 0, 0); cycle(0, 0, 1, 0, 0); idle(1);
        @(negedge sys_clk);
        bus.pi_money_one  = 1'b0;
        bus.pi_money_half = 1'b0;
        bus.pi_cancel     = 1'b0;
        bus.pi_disp_ack   = 1'b0;
        bus.pi_chg_ack    = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge sys_clk);
        check_zero("held_reset");
        sys_rst_n = 1'b1;
        model_reset();
        cycle(1, 0, 0, 0, 0); cycle(0, 1, 0, 0, 0); idle(1);
        cycle(0, 0, 0, 1, 0); idle(2);

        @(negedge sys_clk);
        @(negedge sys_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_seq_ctrl.md
Name: vend_seq_ctrl

Overview:
Sequencing controller for the beverage vending datapath. Accepts coin pulses (0.5 and 1.0 units), tracks credit in half-units, and requests a dispense when credit reaches the price. It then returns change one half-coin at a time through a hopper handshake. It also handles refund-on-cancel and dispenser timeout, and tells the coin mechanism when to reject coins.

Parameters:
PRICE, 3, beverage price in half-units (3 = 1.5); must be >=1.
CNT_W, 3, credit width; PRICE+2 must be < 2**CNT_W.
DISP_TIMEOUT, 1000, cycles to wait for pi_disp_ack before fault/refund; must be >=1.
TO_W, 10, timeout counter width; DISP_TIMEOUT must be < 2**TO_W.

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
pi_money_one  in  1  one-cycle pulse, 1.0 unit inserted (+2 half-units)
pi_money_half  in  1  one-cycle pulse, 0.5 unit inserted (+1 half-unit)
pi_cancel  in  1  one-cycle pulse, refund request
pi_disp_ack  in  1  dispenser has taken the request
pi_chg_ack  in  1  hopper has ejected one half-coin
po_disp_req  out  1  dispense request, level, held until ack
po_chg_req  out  1  eject one half-coin, level, held until ack
po_credit  out  CNT_W  current credit in half-units
po_busy  out  1  high outside ACCUM; coin mechanism must reject coins
po_fault  out  1  one-cycle pulse on dispenser timeout

Behaviour:
- Reset (asynchronous, immediate): state=ACCUM, credit=0, timeout counter=0, and every output is 0. Reset mid-VEND/CHANGE drops all requests at once; any credit held is lost.
- All outputs are registered. po_busy = (next state != ACCUM), registered.
- States: ACCUM, VEND, CHANGE.
- ACCUM:
  - add = 2*pi_money_one + pi_money_half. Both coin pulses in the same cycle give add=3.
  - sum = credit + add, computed at CNT_W bits; it cannot overflow given the PRICE constraint. credit <= sum.
  - If sum >= PRICE: go to VEND; po_disp_req=1 from the next cycle; timeout counter cleared. Vend takes priority over a same-cycle pi_cancel.
  - Else if pi_cancel and sum > 0: go to CHANGE; a coin in the same cycle is included in the refund.
  - Else if pi_cancel and sum == 0: ignored.
- VEND:
  - Coin and cancel inputs are ignored.
  - po_disp_req stays high until pi_disp_ack is sampled high. At that edge: po_disp_req<=0 and credit<=credit-PRICE. Next state is CHANGE if the remainder > 0, else ACCUM.
  - The timeout counter increments each VEND cycle without ack. When it reaches DISP_TIMEOUT-1 with no ack: po_disp_req<=0, po_fault<=1 for one cycle, credit is unchanged (full refund), and the next state is CHANGE.
  - Ack in the same cycle as the timeout: the ack wins and there is no fault.
- CHANGE:
  - Inputs other than pi_chg_ack are ignored.
  - po_chg_req=1 while credit > 0. On each edge where po_chg_req and pi_chg_ack are both high: credit<=credit-1 and po_chg_req<=0 for exactly one cycle. Requests therefore pulse, with at least one low cycle between coins.
  - pi_chg_ack while po_chg_req=0 is ignored.
  - When credit reaches 0: po_chg_req stays 0 and the next state is ACCUM.
- pi_disp_ack outside VEND is ignored.
- Entry latency: coin pulse sampled at edge N → po_credit updated and po_disp_req high after edge N.

Test Plan:
1. PRICE=3; three pi_money_half pulses → po_credit 1,2,3; po_disp_req high after the 3rd; ack → credit 0, state ACCUM, po_chg_req never asserted.
2. Two pi_money_one pulses → after the 2nd, credit=4 and disp_req=1; ack → credit=1, one chg_req; chg_ack → credit=0, ACCUM, busy=0.
3. pi_money_half, then pi_cancel → chg_req=1; ack → credit 0, ACCUM. Also: cancel with credit 0 → no change on any output.
4. DISP_TIMEOUT=8, credit 3, no dispenser ack → po_fault pulses exactly 8 cycles after disp_req rises. Then three chg_req/ack pulses, each followed by a low cycle; ends with credit 0.
5. One+half on the same cycle from credit 0 → credit 3 and disp_req=1. Coins and cancel during VEND leave credit unchanged. Also: cancel with a price-reaching coin → VEND, not CHANGE.
6. Assert sys_rst_n low asynchronously mid-CHANGE with credit 2 → po_chg_req, po_credit and po_busy go 0 without a clock edge. After release, the first coin behaves as from credit 0.
